// File: rtl/instruction_encoder.sv
// Purpose: packs opcode/register/funct fields and a signed immediate into an RV32I word, flags unencodable input.
// Latency: 2 cycles (S1 range check + field pack, S2 output register); throughput 1 word/cycle.
// Backpressure: valid/ready; in_ready is combinational from out_ready, outputs hold while out_valid && !out_ready.
//
// Ports:
//   clk, reset             single clock, synchronous active-high reset
//   in_valid / in_ready    request handshake
//   in_opcode .. in_imm    instruction fields and signed immediate (decoder-style value)
//   out_valid / out_ready  result handshake
//   out_inst, out_err      encoded word and error flag (bad immediate or unknown opcode)
//   err_count              saturating count of transferred error words
module instruction_encoder #(
  parameter int ERR_CNT_W   = 16,
  parameter bit ZERO_ON_ERR = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           in_opcode,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [2:0]           in_funct3,
  input  logic [6:0]           in_funct7,
  input  logic [31:0]          in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_inst,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_LUI       = 7'b0110111;
  localparam logic [6:0] OP_AUIPC     = 7'b0010111;
  localparam logic [6:0] OP_ECALL     = 7'b1110011;

  logic signed [31:0] imm_s;
  logic [31:0]        enc_inst;
  logic               enc_err;

  // I-type is shared by three opcodes, so compute it once.
  logic [31:0] i_inst;
  logic        i_err;

  logic        s1_valid, s1_err;
  logic [31:0] s1_inst;
  logic        s2_valid, s2_err;
  logic [31:0] s2_inst;
  logic        s1_adv, s2_adv;

  assign imm_s  = $signed(in_imm);
  assign i_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
  assign i_err  = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);

  always_comb begin
    enc_inst = 32'h0;
    enc_err  = 1'b0;
    case (in_opcode)
      OP_ARITH: begin
        enc_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      end
      OP_ARITH_IMM: begin
        // Shift-immediates carry a 5-bit shamt with funct7 in the upper bits.
        if (in_funct3 == 3'b001 || in_funct3 == 3'b101) begin
          enc_inst = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
          enc_err  = (imm_s < 32'sd0) || (imm_s > 32'sd31);
        end else begin
          enc_inst = i_inst;
          enc_err  = i_err;
        end
      end
      OP_LOAD, OP_JALR: begin
        enc_inst = i_inst;
        enc_err  = i_err;
      end
      OP_STORE: begin
        enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        enc_err  = i_err;
      end
      OP_BRANCH: begin
        enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
        enc_err  = in_imm[0] || (imm_s < -32'sd4096) || (imm_s > 32'sd4094);
      end
      OP_JAL: begin
        enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        enc_err  = in_imm[0] || (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574);
      end
      OP_LUI, OP_AUIPC: begin
        enc_inst = {in_imm[31:12], in_rd, in_opcode};
        enc_err  = (in_imm[11:0] != 12'h000);
      end
      OP_ECALL: begin
        enc_inst = 32'h0000_0073;
      end
      default: begin
        // Unknown opcode: word is always zero, independent of ZERO_ON_ERR.
        enc_inst = 32'h0;
        enc_err  = 1'b1;
      end
    endcase
  end

  // Ready ripples back combinationally so a full pipe still moves one word per cycle.
  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_inst  <= 32'h0;
      s1_err   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_inst <= enc_inst;
        s1_err  <= enc_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_inst  <= 32'h0;
      s2_err   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_inst <= (ZERO_ON_ERR && s1_err) ? 32'h0 : s1_inst;
        s2_err  <= s1_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= '0;
    end else if (s2_valid && out_ready && s2_err && (err_count != {ERR_CNT_W{1'b1}})) begin
      err_count <= err_count + 1'b1;
    end
  end

  assign out_valid = s2_valid;
  assign out_inst  = s2_inst;
  assign out_err   = s2_err;

endmodule

// File: tb/tb_instruction_encoder.sv
module tb_instruction_encoder;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready, in_ready_b;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid, out_valid_b;
  logic        out_ready;
  logic [31:0] out_inst, out_inst_b;
  logic        out_err, out_err_b;
  logic [15:0] err_count;
  logic [1:0]  err_count_b;

  int total = 0;
  int bad   = 0;
  int popped = 0;

  typedef struct {
    logic [31:0] inst;
    logic        err;
    logic [31:0] raw;
  } exp_t;
  exp_t sb[$];

  instruction_encoder #(.ERR_CNT_W(16), .ZERO_ON_ERR(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_err(out_err), .err_count(err_count)
  );

  // Small counter and truncated-encoding variant, driven with identical stimulus.
  instruction_encoder #(.ERR_CNT_W(2), .ZERO_ON_ERR(1'b0)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_inst(out_inst_b),
    .out_err(out_err_b), .err_count(err_count_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compares every word transferred at the following posedge.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_inst  = 32'h0;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_valid) chk("stall_hold", out_inst, prev_inst);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_word", out_inst, 32'hxxxx_xxxx);
        end else begin
          exp_t e;
          e = sb.pop_front();
          popped++;
          chk("out_inst", out_inst, e.inst);
          chk("out_err", {31'b0, out_err}, {31'b0, e.err});
          chk("b_valid", {31'b0, out_valid_b}, 32'd1);
          chk("b_inst_trunc", out_inst_b, e.raw);
          chk("b_err", {31'b0, out_err_b}, {31'b0, e.err});
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_inst  = out_inst;
    end
  end

  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm, input logic [31:0] ei, input logic ee,
                      input logic [31:0] er);
    int n = 0;
    exp_t e;
    in_valid = 1'b1; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("send_timeout", {31'b0, in_ready}, 32'd1);
      in_valid = 1'b0;
    end else begin
      e.inst = ei; e.err = ee; e.raw = er;
      sb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (sb.size() != 0 && n < 60) begin
      n++;
      @(posedge clk); #1;
    end
    chk("drain_left", sb.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  localparam logic [6:0] ARITH = 7'b0110011, ARITH_IMM = 7'b0010011, LOAD = 7'b0000011,
                         STORE = 7'b0100011, BRANCH = 7'b1100011, JAL = 7'b1101111,
                         JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111,
                         ECALL = 7'b1110011;

  logic saw_low;
  int   pop_start;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_out_err", {31'b0, out_err}, 32'd0);
    chk("rst_err_count", {16'b0, err_count}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Legal encodings: op, rd, rs1, rs2, f3, f7, imm, expected, err, truncated.
    send(ARITH_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5,          32'h00500093, 1'b0, 32'h00500093);
    send(BRANCH,    5'd0, 5'd1, 5'd2, 3'b000, 7'd0, -32'sd4,        32'hFE208EE3, 1'b0, 32'hFE208EE3);
    send(JAL,       5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd8,          32'h008000EF, 1'b0, 32'h008000EF);
    send(LUI,       5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345000,   32'h123452B7, 1'b0, 32'h123452B7);
    send(ARITH,     5'd3, 5'd1, 5'd2, 3'b000, 7'b0100000, 32'hDEAD, 32'h402081B3, 1'b0, 32'h402081B3);
    send(ARITH_IMM, 5'd1, 5'd1, 5'd0, 3'b001, 7'd0, 32'd3,          32'h00309093, 1'b0, 32'h00309093);
    send(STORE,     5'd0, 5'd1, 5'd2, 3'b010, 7'd0, -32'sd8,        32'hFE20AC23, 1'b0, 32'hFE20AC23);
    send(ECALL,     5'd5, 5'd7, 5'd9, 3'b111, 7'd3, 32'd123,        32'h00000073, 1'b0, 32'h00000073);
    send(LOAD,      5'd5, 5'd1, 5'd0, 3'b010, 7'd0, 32'd2047,       32'h7FF0A283, 1'b0, 32'h7FF0A283);
    send(ARITH_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, -32'sd2048,     32'h80000093, 1'b0, 32'h80000093);
    send(JALR,      5'd0, 5'd1, 5'd0, 3'b000, 7'd0, 32'd0,          32'h00008067, 1'b0, 32'h00008067);
    send(AUIPC,     5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h00001000,   32'h00001097, 1'b0, 32'h00001097);
    send(BRANCH,    5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd4094,       32'h7E000FE3, 1'b0, 32'h7E000FE3);
    // Error cases.
    send(ARITH_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd4096,       32'h0, 1'b1, 32'h00000093);
    send(BRANCH,    5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd3,          32'h0, 1'b1, 32'h00208163);
    send(LUI,       5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h00000001,   32'h0, 1'b1, 32'h000002B7);
    drain();
    chk("err_count_3", {16'b0, err_count}, 32'd3);
    send(ARITH_IMM, 5'd1, 5'd1, 5'd0, 3'b001, 7'd0, 32'd32,         32'h0, 1'b1, 32'h00009093);
    send(7'b1111111, 5'd1, 5'd1, 5'd1, 3'b000, 7'd0, 32'd0,         32'h0, 1'b1, 32'h0);
    send(JAL,       5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd3,          32'h0, 1'b1, 32'h002000EF);
    drain();
    chk("err_count_6", {16'b0, err_count}, 32'd6);
    chk("err_count_sat", {30'b0, err_count_b}, 32'd3);

    // Stream 8 words with out_ready low in stream cycles 3..5.
    saw_low = 1'b0;
    pop_start = popped;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send(ARITH, 5'(i + 8), 5'd1, 5'd2, 3'b000, 7'd0, 32'd0,
               32'h00208033 | (32'(i + 8) << 7), 1'b0, 32'h00208033 | (32'(i + 8) << 7));
        end
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 20; c++) begin
          out_ready = !(c >= 3 && c <= 5);
          @(negedge clk);
          if (c >= 3 && c <= 4 && !in_ready) saw_low = 1'b1;
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stream_in_ready_low", {31'b0, saw_low}, 32'd1);
    chk("stream_count", popped - pop_start, 32'd8);

    // Fill both stages under stall, then reset.
    out_ready = 1'b0;
    send(ARITH_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd1, 32'h00100093, 1'b0, 32'h00100093);
    send(ARITH_IMM, 5'd2, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2, 32'h00200113, 1'b0, 32'h00200113);
    in_valid = 1'b0;
    chk("full_out_valid", {31'b0, out_valid}, 32'd1);
    chk("full_in_ready", {31'b0, in_ready}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_err_count", {16'b0, err_count}, 32'd0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_out_valid", {31'b0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
